// File: rtl/bht_update_ctrl.sv
// Purpose: generic circular FIFO with occupancy count; simultaneous push and pop allowed.
// Latency: a pushed entry is visible at pop_dat on the cycle after the push.
// Backpressure: none internally; the owner must not push when full or pop when empty.
module bht_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
endmodule

// Purpose: 2-bit saturating-counter branch table with a queued training path and an init sweep.
// Latency: prediction one cycle after lookup acceptance; queued training drains in the background.
// Backpressure: a full training queue drops both ready signals until one entry has drained.
module bht_update_ctrl #(
    parameter int INDEX_W    = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        lookup_ready,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        train_valid,
    input  logic [31:0] train_pc,
    input  logic        train_taken,
    output logic        train_ready,
    output logic        init_busy
);
    localparam int TBL_N = 2 ** INDEX_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [INDEX_W-1:0] IDX_LAST = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [INDEX_W-1:0] sweep_idx;
    logic [1:0]         tbl [TBL_N];
    logic [INDEX_W-1:0] tbl_addr;
    logic               tbl_we;
    logic [1:0]         tbl_wdat;
    logic [1:0]         tbl_rdat;
    logic [1:0]         ctr_next;
    logic               sweep_wr;
    logic               lookup_fire;
    logic               drain;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [INDEX_W:0]   head;
    logic               pv_q;
    logic               pt_q;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[31:INDEX_W+2], lookup_pc[1:0],
                              train_pc[31:INDEX_W+2], train_pc[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= INIT;
            sweep_idx <= '0;
        end else begin
            state_q <= state_d;
            if (sweep_wr) sweep_idx <= sweep_idx + 1'b1;
        end
    end

    // Full queue wins over lookups so training can never be starved.
    always_comb begin
        state_d      = state_q;
        init_busy    = 1'b1;
        lookup_ready = 1'b0;
        train_ready  = 1'b0;
        sweep_wr     = 1'b0;
        lookup_fire  = 1'b0;
        drain        = 1'b0;
        case (state_q)
            INIT: begin
                sweep_wr = rdy;
                if (rdy && sweep_idx == IDX_LAST) state_d = RUN;
            end
            RUN: begin
                init_busy    = 1'b0;
                train_ready  = rdy && !fifo_full;
                lookup_ready = rdy && !fifo_full && !clr;
                if (rdy) begin
                    if (fifo_full)                         drain       = 1'b1;
                    else if (lookup_valid && lookup_ready) lookup_fire = 1'b1;
                    else if (!fifo_empty)                  drain       = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign push = train_valid && train_ready;

    bht_fifo #(
        .WIDTH (INDEX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({train_pc[INDEX_W+1:2], train_taken}),
        .pop      (drain),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // Single table port: sweep, drain and lookup are mutually exclusive by construction.
    always_comb begin
        tbl_we   = 1'b0;
        tbl_addr = lookup_pc[INDEX_W+1:2];
        if (sweep_wr) begin
            tbl_we   = 1'b1;
            tbl_addr = sweep_idx;
        end else if (drain) begin
            tbl_we   = 1'b1;
            tbl_addr = head[INDEX_W:1];
        end
    end

    assign tbl_rdat = tbl[tbl_addr];

    always_comb begin
        ctr_next = tbl_rdat;
        if (head[0]) begin
            if (tbl_rdat != 2'b11) ctr_next = tbl_rdat + 2'd1;
        end else begin
            if (tbl_rdat != 2'b00) ctr_next = tbl_rdat - 2'd1;
        end
    end

    assign tbl_wdat = sweep_wr ? 2'b01 : ctr_next;

    always_ff @(posedge clk) begin
        if (tbl_we) tbl[tbl_addr] <= tbl_wdat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_q <= 1'b0;
            pt_q <= 1'b0;
        end else if (rdy) begin
            pv_q <= lookup_fire;
            if (lookup_fire) pt_q <= tbl_rdat[1];
        end
    end

    // A flush squashes the in-flight prediction without disturbing the held register.
    assign pred_valid = pv_q && !clr;
    assign pred_taken = pt_q;
endmodule

// File: tb/tb_bht_update_ctrl.sv
// Scoreboard bench for bht_update_ctrl: a counter model predicts every lookup result.
module tb_bht_update_ctrl;
    localparam int IW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        lookup_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        train_valid = 1'b0;
    logic [31:0] train_pc = '0;
    logic        train_taken = 1'b0;
    logic        train_ready;
    logic        init_busy;

    int   errors = 0;
    int   checks = 0;
    logic [1:0] mdl [2**IW];
    logic exp_q [$];

    bht_update_ctrl #(.INDEX_W(IW), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .clr          (clr),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .lookup_ready (lookup_ready),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .train_valid  (train_valid),
        .train_pc     (train_pc),
        .train_taken  (train_taken),
        .train_ready  (train_ready),
        .init_busy    (init_busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mdl_init();
        foreach (mdl[i]) mdl[i] = 2'b01;
    endtask

    task automatic mdl_train(input logic [31:0] pc, input logic tk);
        logic [IW-1:0] ix;
        ix = pc[IW+1:2];
        if (tk) begin
            if (mdl[ix] != 2'b11) mdl[ix] = mdl[ix] + 2'd1;
        end else begin
            if (mdl[ix] != 2'b00) mdl[ix] = mdl[ix] - 2'd1;
        end
    endtask

    task automatic push_train(input logic [31:0] pc, input logic tk);
        bit done = 0;
        train_valid = 1'b1; train_pc = pc; train_taken = tk;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (train_ready) begin done = 1; mdl_train(pc, tk); end
            @(posedge clk); #1;
        end
        train_valid = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL train_accept: got no handshake within 20 cycles, required train_ready=1");
        end
    endtask

    task automatic issue_lookup(input logic [31:0] pc, output bit acc);
        logic [31:0] p;
        p = pc;
        lookup_valid = 1'b1; lookup_pc = pc;
        @(negedge clk);
        acc = lookup_ready;
        exp_q.push_back(mdl[p[IW+1:2]][1]);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        rdy = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred_valid: got %b required 0", pred_valid); end
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b required 1", init_busy); end
        checks++; if (lookup_ready !== 1'b0 || train_ready !== 1'b0) begin errors++; $display("FAIL reset_readies: got lookup_ready=%b train_ready=%b required 0/0", lookup_ready, train_ready); end
        checks++; if (dut.fifo_cnt !== 0) begin errors++; $display("FAIL reset_count: got %0d required 0", dut.fifo_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        mdl_init();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!init_busy) break;
            n++;
        end
        checks++; if (n !== 64) begin errors++; $display("FAIL init_cycles: got %0d required 64", n); end
        checks++; if (lookup_ready !== 1'b1 || train_ready !== 1'b1) begin errors++; $display("FAIL run_readies: got lookup_ready=%b train_ready=%b required 1/1", lookup_ready, train_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_first_lookup();
        bit acc;
        logic e;
        issue_lookup(32'h40, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL first_accept: got %b required 1", acc); end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL first_pred: got valid=%b taken=%b required valid=1 taken=%b", pred_valid, pred_taken, e); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL pred_one_cycle: got %b required 0", pred_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_train();
        bit          acc;
        logic        e;
        bit          ph_tk [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int          ph_n  [5] = '{2, 3, 1, 5, 1};
        logic [31:0] ph_pc [5] = '{32'h100, 32'h100, 32'hABCD_0103, 32'h200, 32'h100};
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < ph_n[p]; k++) push_train(32'h100, ph_tk[p]);
            step(8);
            issue_lookup(ph_pc[p], acc);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL train_phase%0d: got valid=%b taken=%b required valid=1 taken=%b", p, pred_valid, pred_taken, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full();
        bit   acc;
        logic e;
        lookup_valid = 1'b1; lookup_pc = 32'h80;
        for (int i = 0; i < 4; i++) begin
            train_valid = 1'b1; train_pc = 32'((i + 1) * 4); train_taken = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL fill_pred%0d: got valid=%b taken=%b required valid=1 taken=%b", i, pred_valid, pred_taken, e); end
            end
            checks++; if (train_ready !== 1'b1 || lookup_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got train=%b lookup=%b required 1/1", i, train_ready, lookup_ready); end
            exp_q.push_back(mdl[32][1]);
            mdl_train(train_pc, 1'b1);
            @(posedge clk); #1;
        end
        train_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL fill_pred_last: got valid=%b taken=%b required valid=1 taken=%b", pred_valid, pred_taken, e); end
        checks++; if (train_ready !== 1'b0 || lookup_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got train=%b lookup=%b required 0/0", train_ready, lookup_ready); end
        checks++; if (dut.fifo_cnt !== 4) begin errors++; $display("FAIL full_count: got %0d required 4", dut.fifo_cnt); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL full_no_lookup: got %b required 0", pred_valid); end
        checks++; if (lookup_ready !== 1'b1 || dut.fifo_cnt !== 3) begin errors++; $display("FAIL after_drain: got lookup_ready=%b count=%0d required 1/3", lookup_ready, dut.fifo_cnt); end
        exp_q.push_back(mdl[32][1]);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL resume_pred: got valid=%b taken=%b required valid=1 taken=%b", pred_valid, pred_taken, e); end
        @(posedge clk); #1;
        step(8);
        issue_lookup(32'h4, acc);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL full_drained: got valid=%b taken=%b required valid=1 taken=%b", pred_valid, pred_taken, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_clr();
        bit   acc;
        logic e;
        lookup_valid = 1'b1; lookup_pc = 32'h4;
        train_valid = 1'b1; train_pc = 32'h8; train_taken = 1'b1;
        @(negedge clk);
        checks++; if (lookup_ready !== 1'b1 || train_ready !== 1'b1) begin errors++; $display("FAIL clr_setup: got lookup=%b train=%b required 1/1", lookup_ready, train_ready); end
        exp_q.push_back(mdl[1][1]);
        mdl_train(32'h8, 1'b1);
        @(posedge clk); #1;
        train_valid = 1'b0; clr = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL clr_pred: got %b required 0 (discarded taken=%b)", pred_valid, e); end
        checks++; if (lookup_ready !== 1'b0 || train_ready !== 1'b1) begin errors++; $display("FAIL clr_readies: got lookup=%b train=%b required 0/1", lookup_ready, train_ready); end
        checks++; if (dut.fifo_cnt !== 1) begin errors++; $display("FAIL clr_count: got %0d required 1", dut.fifo_cnt); end
        @(posedge clk); #1;
        clr = 1'b0; lookup_valid = 1'b0;
        @(negedge clk);
        checks++; if (pred_valid !== 1'b0 || dut.fifo_cnt !== 0) begin errors++; $display("FAIL clr_after: got valid=%b count=%0d required 0/0", pred_valid, dut.fifo_cnt); end
        @(posedge clk); #1;
        step(4);
        issue_lookup(32'h8, acc);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL clr_table: got valid=%b taken=%b required valid=1 taken=%b", pred_valid, pred_taken, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_rdy_run();
        bit   acc;
        logic e;
        lookup_valid = 1'b1; lookup_pc = 32'hC;
        train_valid = 1'b1; train_pc = 32'h10; train_taken = 1'b0;
        @(negedge clk);
        exp_q.push_back(mdl[3][1]);
        if (train_ready) mdl_train(32'h10, 1'b0);
        @(posedge clk); #1;
        lookup_valid = 1'b0; train_valid = 1'b0; rdy = 1'b0;
        e = exp_q.pop_front();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (pred_valid !== 1'b1 || pred_taken !== e || dut.fifo_cnt !== 1) begin errors++; $display("FAIL rdy_hold%0d: got valid=%b taken=%b count=%0d required 1/%b/1", c, pred_valid, pred_taken, dut.fifo_cnt, e); end
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        step(1);
        @(negedge clk);
        checks++; if (pred_valid !== 1'b0 || dut.fifo_cnt !== 0) begin errors++; $display("FAIL rdy_release: got valid=%b count=%0d required 0/0", pred_valid, dut.fifo_cnt); end
        @(posedge clk); #1;
        issue_lookup(32'h10, acc);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL rdy_drain: got valid=%b taken=%b required valid=1 taken=%b", pred_valid, pred_taken, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit   acc;
        logic e;
        int   n = 0;
        lookup_valid = 1'b1; lookup_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            train_valid = 1'b1; train_pc = 32'h20 + 32'(i * 4); train_taken = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
        end
        train_valid = 1'b0;
        checks++; if (dut.fifo_cnt !== 3 || pred_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got count=%0d valid=%b required 3/1", dut.fifo_cnt, pred_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (dut.fifo_cnt !== 0 || pred_valid !== 1'b0) begin errors++; $display("FAIL rst_async: got count=%0d valid=%b required 0/0", dut.fifo_cnt, pred_valid); end
        checks++; if (init_busy !== 1'b1 || dut.sweep_idx !== 0) begin errors++; $display("FAIL rst_init: got busy=%b sweep=%0d required 1/0", init_busy, dut.sweep_idx); end
        exp_q.delete();
        lookup_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mdl_init();
        for (int c = 0; c < 300; c++) begin
            if (c == 10) begin
                checks++; if (dut.sweep_idx !== 10) begin errors++; $display("FAIL sweep_at10: got %0d required 10", dut.sweep_idx); end
                rdy = 1'b0;
            end
            if (c == 15) begin
                checks++; if (dut.sweep_idx !== 10 || lookup_ready !== 1'b0) begin errors++; $display("FAIL sweep_hold: got sweep=%0d lookup_ready=%b required 10/0", dut.sweep_idx, lookup_ready); end
                rdy = 1'b1;
            end
            @(negedge clk);
            if (!init_busy) break;
            n++;
            @(posedge clk); #1;
        end
        checks++; if (n !== 69) begin errors++; $display("FAIL init_stretched: got %0d required 69", n); end
        @(posedge clk); #1;
        issue_lookup(32'h4, acc);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++; if (pred_valid !== 1'b1 || pred_taken !== e) begin errors++; $display("FAIL reinit_table: got valid=%b taken=%b required valid=1 taken=%b", pred_valid, pred_taken, e); end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_lookup();
        test_train();
        test_full();
        test_clr();
        test_rdy_run();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
